// File: rtl/bram_port_master.sv
// Purpose : requester-side controller for a one-cycle negedge block RAM; turns
//           valid/ready load/store requests into registered BRAM RD/WR strobes.
// Latency : loads return 1 cycle after accept; full stores are posted (1/cycle);
//           partial stores take a read-modify-write and hold the port 2 cycles.
// Backpr. : req_ready drops while a load/RMW is in flight or a response is held
//           and not being consumed in the same cycle.
//
// Ports
//   clk, rst            single clock; synchronous active-high reset
//   req_*               request channel (req_addr is a byte address, [1:0] ignored)
//   resp_*              single-entry load response register
//   bram_*              registered BRAM write/read strobes, data in from BRAM
//
// Build option
//   BRAM_PORT_MASTER_RMW_EN : when defined, stores with a partial byte mask are
//   merged with the current word via read-modify-write. When undefined, req_be
//   is ignored and every store writes the full word.
module bram_port_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    input  logic [ADDR_WIDTH+1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_rdata,
    output logic                      bram_we,
    output logic [ADDR_WIDTH-1:0]     bram_wr_addr,
    output logic [DATA_WIDTH-1:0]     bram_di,
    output logic                      bram_re,
    output logic [ADDR_WIDTH-1:0]     bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]     bram_do,
    input  logic                      bram_do_valid
);

    localparam int BW = DATA_WIDTH / 8;

`ifdef BRAM_PORT_MASTER_RMW_EN
    typedef enum logic [1:0] {IDLE, READ, RMW_RD, RMW_WR} state_t;
`else
    typedef enum logic {IDLE, READ} state_t;
`endif

    state_t state;

    // Word index; upper byte-address bits beyond the port width are already gone,
    // so the word address wraps naturally.
    logic [ADDR_WIDTH-1:0] req_word;
    logic                  accept;

    assign req_word  = req_addr[ADDR_WIDTH+1:2];
    assign req_ready = (state == IDLE) && (!resp_valid || resp_ready) && !rst;
    assign accept    = req_valid && req_ready;

`ifdef BRAM_PORT_MASTER_RMW_EN
    logic [BW-1:0]         rmw_be;
    logic [DATA_WIDTH-1:0] rmw_wdata;
    logic                  unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];
`else
    logic unused_in;
    assign unused_in = ^{req_addr[1:0], req_be};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            bram_we      <= 1'b0;
            bram_wr_addr <= '0;
            bram_di      <= '0;
            bram_re      <= 1'b0;
            bram_rd_addr <= '0;
`ifdef BRAM_PORT_MASTER_RMW_EN
            rmw_be       <= '0;
            rmw_wdata    <= '0;
`endif
        end else begin
            // Write strobe is a one-cycle pulse unless re-armed below.
            bram_we <= 1'b0;

            // Pop first; a load completing in READ cannot coincide with a held
            // response because loads are only accepted once the slot is free.
            if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_we) begin
`ifdef BRAM_PORT_MASTER_RMW_EN
                            if (&req_be) begin
                                bram_we      <= 1'b1;
                                bram_wr_addr <= req_word;
                                bram_di      <= req_wdata;
                            end else if (|req_be) begin
                                // Fetch the old word; merge happens on DO_VALID.
                                bram_re      <= 1'b1;
                                bram_rd_addr <= req_word;
                                bram_wr_addr <= req_word;
                                rmw_be       <= req_be;
                                rmw_wdata    <= req_wdata;
                                state        <= RMW_RD;
                            end
`else
                            bram_we      <= 1'b1;
                            bram_wr_addr <= req_word;
                            bram_di      <= req_wdata;
`endif
                        end else begin
                            bram_re      <= 1'b1;
                            bram_rd_addr <= req_word;
                            state        <= READ;
                        end
                    end
                end

                READ: begin
                    if (bram_do_valid) begin
                        resp_rdata <= bram_do;
                        resp_valid <= 1'b1;
                        bram_re    <= 1'b0;
                        state      <= IDLE;
                    end
                end

`ifdef BRAM_PORT_MASTER_RMW_EN
                RMW_RD: begin
                    if (bram_do_valid) begin
                        for (int b = 0; b < BW; b++) begin
                            bram_di[8*b +: 8] <= rmw_be[b] ? rmw_wdata[8*b +: 8]
                                                           : bram_do[8*b +: 8];
                        end
                        bram_we <= 1'b1;
                        bram_re <= 1'b0;
                        state   <= RMW_WR;
                    end
                end

                RMW_WR: begin
                    // Write pulse issued last cycle lands at this cycle's negedge.
                    state <= IDLE;
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule
